// File: rtl/matmul_partition_mac_pipe.sv
// Pipelined multiply-accumulate: operand beats travel NUM_STAGE tagged stages, then a
// final IDLE/ACCUM stage emits standalone products or accumulated group sums.
module matmul_partition_mac_pipe #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 32,
    parameter int DOUT_WIDTH = 32,
    parameter int NUM_STAGE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  signed_mode,
    input  logic                  acc_en,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout
);

    typedef struct packed {
        logic                  sgn;
        logic                  en;
        logic                  last;
        logic [DIN0_WIDTH-1:0] a;
        logic [DIN1_WIDTH-1:0] b;
    } beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    logic                  advance;
    beat_t                 beat_d;
    logic                  vld_q  [NUM_STAGE];
    beat_t                 beat_q [NUM_STAGE];
    beat_t                 t_beat;
    logic                  t_vld;
    logic [DOUT_WIDTH-1:0] a_ext;
    logic [DOUT_WIDTH-1:0] b_ext;
    logic [DOUT_WIDTH-1:0] prod;
    logic [DOUT_WIDTH-1:0] base;
    logic [DOUT_WIDTH-1:0] total;
    state_e                state_q;
    logic [DOUT_WIDTH-1:0] sum_q;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  out_valid_q;

    // Whole pipe moves as one; a held output freezes every stage.
    assign advance   = ce && (!out_valid_q || out_ready);
    assign in_ready  = reset && advance;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

    assign beat_d = '{sgn: signed_mode, en: acc_en, last: acc_last, a: din0, b: din1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                vld_q[i]  <= 1'b0;
                beat_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q[0]  <= in_valid;
            beat_q[0] <= beat_d;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                vld_q[i]  <= vld_q[i-1];
                beat_q[i] <= beat_q[i-1];
            end
        end
    end

    assign t_beat = beat_q[NUM_STAGE-1];
    assign t_vld  = vld_q[NUM_STAGE-1];

    // Operands extended straight to DOUT_WIDTH: the low DOUT_WIDTH bits of the product
    // only depend on the low DOUT_WIDTH bits of each extended operand.
    for (genvar g = 0; g < DOUT_WIDTH; g++) begin : g_ext
        if (g < DIN0_WIDTH) begin : g_a_bit
            assign a_ext[g] = t_beat.a[g];
        end else begin : g_a_sx
            assign a_ext[g] = t_beat.sgn & t_beat.a[DIN0_WIDTH-1];
        end
        if (g < DIN1_WIDTH) begin : g_b_bit
            assign b_ext[g] = t_beat.b[g];
        end else begin : g_b_sx
            assign b_ext[g] = t_beat.sgn & t_beat.b[DIN1_WIDTH-1];
        end
    end

    always_comb begin
        prod  = a_ext * b_ext;
        base  = (state_q == ACCUM) ? sum_q : '0;
        total = base + prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            out_valid_q <= 1'b0;
            if (t_vld) begin
                case (state_q)
                    IDLE: begin
                        if (!t_beat.en) begin
                            dout_q      <= prod;
                            out_valid_q <= 1'b1;
                        end else if (!t_beat.last) begin
                            sum_q   <= prod;
                            state_q <= ACCUM;
                        end else begin
                            dout_q      <= prod;
                            out_valid_q <= 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (!t_beat.en) begin
                            dout_q      <= prod;
                            out_valid_q <= 1'b1;
                            sum_q       <= '0;
                            state_q     <= IDLE;
                        end else if (!t_beat.last) begin
                            sum_q <= total;
                        end else begin
                            dout_q      <= total;
                            out_valid_q <= 1'b1;
                            sum_q       <= '0;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matmul_partition_mac_pipe.sv
// Directed bench: transaction-level model (group arithmetic at acceptance, results due
// NUM_STAGE handshake edges later) checked every cycle, plus hand-computed literals.
module tb_matmul_partition_mac_pipe;

    localparam int NS = 2;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        signed_mode;
    logic        acc_en;
    logic        acc_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;

    int vectors     = 0;
    int miscompares = 0;

    matmul_partition_mac_pipe #(
        .DIN0_WIDTH(32),
        .DIN1_WIDTH(32),
        .DOUT_WIDTH(32),
        .NUM_STAGE (NS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din0       (din0),
        .din1       (din1),
        .signed_mode(signed_mode),
        .acc_en     (acc_en),
        .acc_last   (acc_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product: plain 64-bit integer arithmetic, truncated to 32 bits.
    function automatic logic [31:0] mprod(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint      x;
        longint      y;
        logic [63:0] p;
        if (s) begin
            x = longint'(signed'(a));
            y = longint'(signed'(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        p = x * y;
        return p[31:0];
    endfunction

    typedef struct {
        int          due;
        bit          emit;
        logic [31:0] val;
    } ent_t;

    ent_t        q[$];
    int          adv_n = 0;
    logic        m_ov = 1'b0;
    logic [31:0] m_dout = '0;
    bit          m_grp = 1'b0;
    logic [31:0] m_sum = '0;

    // Inputs are driven just after posedge, so values seen here are those of the next edge.
    always @(negedge clk) begin
        logic        exp_rdy;
        ent_t        e;
        logic [31:0] p;
        if (!reset) begin
            check("reset_out_valid", {31'd0, out_valid}, 32'd0);
            check("reset_dout", dout, 32'd0);
            check("reset_in_ready", {31'd0, in_ready}, 32'd0);
            q.delete();
            m_ov   = 1'b0;
            m_dout = '0;
            m_grp  = 1'b0;
            m_sum  = '0;
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            check("dout", dout, m_dout);
            exp_rdy = ce && (!m_ov || out_ready);
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (exp_rdy) begin
                adv_n++;
                m_ov = 1'b0;
                if (q.size() > 0 && q[0].due == adv_n) begin
                    e = q.pop_front();
                    if (e.emit) begin
                        m_ov   = 1'b1;
                        m_dout = e.val;
                    end
                end
                if (in_valid) begin
                    p     = mprod(din0, din1, signed_mode);
                    e.due = adv_n + NS;
                    if (!acc_en) begin
                        e.emit = 1'b1;
                        e.val  = p;
                        m_grp  = 1'b0;
                        m_sum  = '0;
                    end else if (!acc_last) begin
                        e.emit = 1'b0;
                        e.val  = '0;
                        m_sum  = m_grp ? m_sum + p : p;
                        m_grp  = 1'b1;
                    end else begin
                        e.emit = 1'b1;
                        e.val  = (m_grp ? m_sum : 32'd0) + p;
                        m_grp  = 1'b0;
                        m_sum  = '0;
                    end
                    q.push_back(e);
                end
            end
        end
    end

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input bit s, input bit en,
                        input bit last);
        bit acc;
        in_valid    = 1'b1;
        din0        = a;
        din1        = b;
        signed_mode = s;
        acc_en      = en;
        acc_last    = last;
        acc         = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int cyc, output logic [31:0] v);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        v    = '0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) begin
                seen = 1'b1;
                v    = dout;
            end
        end
        if (!seen) cyc = -1;
    endtask

    logic [31:0] got[$];
    int          gcyc[$];

    task automatic collect(input int n);
        got.delete();
        gcyc.delete();
        for (int k = 0; k < n; k++) begin
            bit dacc;
            @(negedge clk);
            if (out_valid && out_ready) begin
                got.push_back(dout);
                gcyc.push_back(k);
            end
            dacc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (dacc) in_valid = 1'b0;
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] v;
        reset       = 1'b0;
        ce          = 1'b1;
        in_valid    = 1'b0;
        din0        = '0;
        din1        = '0;
        signed_mode = 1'b0;
        acc_en      = 1'b0;
        acc_last    = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("lit_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("lit_reset_dout", dout, 32'd0);
        check("lit_reset_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;

        // Signed -3 x 7, standalone
        beat(-3, 7, 1'b1, 1'b0, 1'b0);
        idle();
        wait_ov(cyc, v);
        check("lat_signed", cyc, 32'd2);
        check("val_signed", v, 32'hFFFF_FFEB);

        // Truncation, unsigned and signed
        beat(32'hFFFF_FFFF, 2, 1'b0, 1'b0, 1'b0);
        idle();
        wait_ov(cyc, v);
        check("val_unsigned_trunc", v, 32'hFFFF_FFFE);
        beat(32'hFFFF_FFFF, 2, 1'b1, 1'b0, 1'b0);
        idle();
        wait_ov(cyc, v);
        check("val_signed_trunc", v, 32'hFFFF_FFFE);

        // Four-beat group, single result 30
        beat(1, 1, 1'b0, 1'b1, 1'b0);
        beat(2, 2, 1'b0, 1'b1, 1'b0);
        beat(3, 3, 1'b0, 1'b1, 1'b0);
        beat(4, 4, 1'b0, 1'b1, 1'b1);
        idle();
        collect(8);
        check("group_count", got.size(), 32'd1);
        if (got.size() >= 1) check("group_sum", got[0], 32'd30);

        // Mixed signedness inside one group: -6 + 0xFFFFFFFF - 4
        beat(-2, 3, 1'b1, 1'b1, 1'b0);
        beat(32'hFFFF_FFFF, 1, 1'b0, 1'b1, 1'b0);
        beat(4, -1, 1'b1, 1'b1, 1'b1);
        idle();
        collect(8);
        check("mixed_count", got.size(), 32'd1);
        if (got.size() >= 1) check("mixed_sum", got[0], 32'hFFFF_FFF5);

        // acc_en=0 during ACCUM drops the partial sum
        beat(10, 10, 1'b0, 1'b1, 1'b0);
        beat(3, 3, 1'b0, 1'b0, 1'b0);
        beat(1, 1, 1'b0, 1'b1, 1'b1);
        idle();
        collect(8);
        check("discard_count", got.size(), 32'd2);
        if (got.size() >= 2) begin
            check("discard_first", got[0], 32'd9);
            check("discard_second", got[1], 32'd1);
        end

        // Backpressure: hold for 5 cycles, then drain back-to-back
        out_ready = 1'b0;
        beat(3, 4, 1'b0, 1'b0, 1'b0);
        beat(5, 6, 1'b0, 1'b0, 1'b0);
        beat(7, 8, 1'b0, 1'b0, 1'b0);
        din0 = 9;
        din1 = 10;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_dout", dout, 32'd12);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        collect(10);
        check("drain_count", got.size(), 32'd4);
        if (got.size() >= 4) begin
            check("drain_0", got[0], 32'd12);
            check("drain_1", got[1], 32'd30);
            check("drain_2", got[2], 32'd56);
            check("drain_3", got[3], 32'd90);
            check("drain_span", gcyc[3] - gcyc[0], 32'd3);
        end

        // Reset mid-accumulation
        beat(2, 3, 1'b0, 1'b1, 1'b0);
        beat(4, 5, 1'b0, 1'b1, 1'b0);
        idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        collect(6);
        check("midrst_no_output", got.size(), 32'd0);
        beat(5, 5, 1'b0, 1'b1, 1'b1);
        idle();
        wait_ov(cyc, v);
        check("midrst_lat", cyc, 32'd2);
        check("midrst_val", v, 32'd25);

        // ce low for 3 cycles with two beats in flight
        beat(6, 7, 1'b0, 1'b0, 1'b0);
        beat(8, 9, 1'b0, 1'b0, 1'b0);
        idle();
        ce = 1'b0;
        got.delete();
        gcyc.delete();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) ce = 1'b1;
            if (out_valid) begin
                got.push_back(dout);
                gcyc.push_back(k);
            end
        end
        check("ce_count", got.size(), 32'd2);
        if (got.size() >= 2) begin
            check("ce_first_lat", gcyc[0], 32'd4);
            check("ce_first_val", got[0], 32'd42);
            check("ce_second_lat", gcyc[1], 32'd5);
            check("ce_second_val", got[1], 32'd72);
        end

        // Mixed stream with occasional stalls; checked by the model every cycle
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 1) begin
                idle();
                out_ready = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            if (i % 6 == 5) begin
                ce = 1'b0;
                @(posedge clk);
                #1;
                ce = 1'b1;
            end
            beat(32'(i * 1234567 - 5000000), 32'(17 - i * i * i), 1'(i % 2),
                 (i % 5 != 0), (i % 5 == 4) || (i % 7 == 3));
        end
        beat(11, 13, 1'b0, 1'b1, 1'b1);
        idle();
        repeat (10) begin
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matmul_partition_mac_pipe.md
MATMUL_PARTITION_MAC_PIPE -- requirements
Module: matmul_partition_mac_pipe

Interface
REQ-001 SHALL expose parameter DIN0_WIDTH, default 32, operand 0 width.
REQ-002 SHALL expose parameter DIN1_WIDTH, default 32, operand 1 width.
REQ-003 SHALL expose parameter DOUT_WIDTH, default 32, result/accumulator width.
REQ-004 SHALL expose parameter NUM_STAGE, default 2, legal 1..4, pipeline depth from input acceptance to out_valid.
REQ-005 SHALL provide port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL provide port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide port ce, input, 1, global clock enable; low freezes all state.
REQ-008 SHALL provide port in_valid, input, 1, operand beat present.
REQ-009 SHALL provide port in_ready, output, 1, block accepts beat this cycle.
REQ-010 SHALL provide port din0, input, DIN0_WIDTH, operand 0.
REQ-011 SHALL provide port din1, input, DIN1_WIDTH, operand 1.
REQ-012 SHALL provide port signed_mode, input, 1, 1 = signed operands, 0 = unsigned; sampled per beat.
REQ-013 SHALL provide port acc_en, input, 1, add product into running sum; sampled per beat.
REQ-014 SHALL provide port acc_last, input, 1, final beat of accumulation group; sampled per beat.
REQ-015 SHALL provide port out_valid, output, 1, dout holds a result.
REQ-016 SHALL provide port out_ready, input, 1, downstream consumes result.
REQ-017 SHALL provide port dout, output, DOUT_WIDTH, result.

Function
REQ-018 Beat accepted when in_valid && in_ready; in_ready = ce && (!out_valid || out_ready) (whole-pipe stall, no bubble collapse).
REQ-019 Product: operands sign- or zero-extended per signed_mode to DIN0_WIDTH+DIN1_WIDTH, full product formed, then truncated/extended to DOUT_WIDTH (modulo 2^DOUT_WIDTH).
REQ-020 Each of NUM_STAGE stages carries a valid bit plus signed_mode/acc_en/acc_last tags; stages advance only when ce && (!out_valid || out_ready).
REQ-021 Unstalled latency: beat accepted at edge N produces out_valid at edge N+NUM_STAGE.
REQ-022 Accumulator FSM in final stage, states IDLE and ACCUM; reset state IDLE, sum = 0.
REQ-023 IDLE, beat acc_en=0: dout = product, out_valid=1, stay IDLE.
REQ-024 IDLE, beat acc_en=1, acc_last=0: sum = product, no output, go ACCUM.
REQ-025 ACCUM, beat acc_en=1, acc_last=0: sum = sum + product (mod 2^DOUT_WIDTH), no output.
REQ-026 IDLE/ACCUM, beat acc_en=1, acc_last=1: dout = sum_or_0 + product, out_valid=1, sum cleared, go IDLE.
REQ-027 ACCUM, beat acc_en=0: emits product alone, partial sum discarded, go IDLE.
REQ-028 out_valid && !out_ready: dout and out_valid held stable, in_ready=0.
REQ-029 out_valid && out_ready with new result arriving same edge: new result replaces old, out_valid stays 1.
REQ-030 ce=0: no state change, in_ready=0, outputs held.
REQ-031 Signedness tag travels with beat; mixed-mode beats inside one group legal, each product per own tag.

Reset
REQ-032 reset low SHALL asynchronously clear all stage valids, out_valid=0, dout=0, sum=0, FSM=IDLE.
REQ-033 reset asserted mid-accumulation or mid-pipe SHALL discard all in-flight beats; no result emitted after release.
REQ-034 in_ready SHALL be 0 while reset low; first acceptance possible on first edge after release.

Verification
REQ-035 NUM_STAGE=2, signed: din0=-3, din1=7, acc_en=0 -> out_valid 2 cycles later, dout=0xFFFFFFEB (-21).
REQ-036 Unsigned: din0=0xFFFFFFFF, din1=2 -> dout=0xFFFFFFFE (truncated); same operands signed -> 0xFFFFFFFE.
REQ-037 Group 4 beats (1x1,2x2,3x3,4x4, acc_last on 4th) -> single out_valid, dout=30; no intermediate outputs.
REQ-038 out_ready=0 for 5 cycles while out_valid=1 -> dout held, in_ready=0, no beat lost after release; back-to-back stream at out_ready=1 -> one result per cycle.
REQ-039 reset pulsed after 2 beats of a group -> out_valid=0, next standalone beat 5x5 returns 25 (no stale sum).
REQ-040 ce=0 for 3 cycles mid-stream -> latency extends by exactly 3, results unchanged.
